// File: rtl/hicore_icb_arbt2.sv
// Two-master ICB arbiter (m0 = LSU, m1 = IFU) feeding the bus-interface splitter.
// Define HICORE_ICB_ARBT_RR_EN for round-robin arbitration; the default build uses fixed m0 priority.
module hicore_icb_arbt2 #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int OUTS_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_icb_cmd_valid,
  output logic            m0_icb_cmd_ready,
  input  logic            m0_icb_cmd_read,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_rsp_valid,
  input  logic            m0_icb_rsp_ready,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,

  input  logic            m1_icb_cmd_valid,
  output logic            m1_icb_cmd_ready,
  input  logic            m1_icb_cmd_read,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_rsp_valid,
  input  logic            m1_icb_rsp_ready,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,

  output logic            o_icb_cmd_valid,
  input  logic            o_icb_cmd_ready,
  output logic            o_icb_cmd_read,
  output logic [AW-1:0]   o_icb_cmd_addr,
  output logic [DW-1:0]   o_icb_cmd_wdata,
  output logic [DW/8-1:0] o_icb_cmd_wmask,
  input  logic            o_icb_rsp_valid,
  output logic            o_icb_rsp_ready,
  input  logic            o_icb_rsp_err,
  input  logic [DW-1:0]   o_icb_rsp_rdata
);

  // Handshake rule on every channel: a transfer happens in a cycle where valid
  // and ready are both high; valid never waits on ready, and a stalled command
  // keeps its grant until it transfers.

  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CW = $clog2(OUTS_DEPTH + 1);

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic          fifo_q [OUTS_DEPTH];
  logic          lock_q;
  logic          lock_sel_q;

  logic sel;
  logic sel_valid;
  logic full;
  logic empty;
  logic head;
  logic cmd_hsk;
  logic rsp_hsk;

`ifdef HICORE_ICB_ARBT_RR_EN
  logic rr_last_q;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(OUTS_DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rptr_q];

  // Grant: a stalled (locked) master is never pre-empted.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
`ifdef HICORE_ICB_ARBT_RR_EN
      sel = ~rr_last_q;
`else
      sel = 1'b0;
`endif
    end else if (m1_icb_cmd_valid) begin
      sel = 1'b1;
    end
  end

  assign sel_valid = sel ? m1_icb_cmd_valid : m0_icb_cmd_valid;

  // Command path: pure mux, no added latency; full blocks new commands.
  assign o_icb_cmd_valid  = sel_valid & ~full;
  assign o_icb_cmd_read   = sel ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign o_icb_cmd_addr   = sel ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign o_icb_cmd_wdata  = sel ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign o_icb_cmd_wmask  = sel ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  assign m0_icb_cmd_ready = ~sel & m0_icb_cmd_valid & o_icb_cmd_ready & ~full;
  assign m1_icb_cmd_ready =  sel & m1_icb_cmd_valid & o_icb_cmd_ready & ~full;
  assign cmd_hsk          = o_icb_cmd_valid & o_icb_cmd_ready;

  // Response path: steered by the oldest outstanding command's master.
  assign m0_icb_rsp_valid = o_icb_rsp_valid & ~empty & ~head;
  assign m1_icb_rsp_valid = o_icb_rsp_valid & ~empty &  head;
  assign m0_icb_rsp_err   = o_icb_rsp_err;
  assign m1_icb_rsp_err   = o_icb_rsp_err;
  assign m0_icb_rsp_rdata = o_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = o_icb_rsp_rdata;
  assign o_icb_rsp_ready  = ~empty & (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign rsp_hsk          = o_icb_rsp_valid & o_icb_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      if (cmd_hsk) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (rsp_hsk) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({cmd_hsk, rsp_hsk})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (o_icb_cmd_valid && !o_icb_cmd_ready) begin
        lock_q     <= 1'b1;
        lock_sel_q <= sel;
      end else if (cmd_hsk) begin
        lock_q     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTS_DEPTH; i++) begin
        fifo_q[i] <= 1'b0;
      end
    end else if (cmd_hsk) begin
      fifo_q[wptr_q] <= sel;
    end
  end

`ifdef HICORE_ICB_ARBT_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else if (cmd_hsk) begin
      rr_last_q <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_hicore_icb_arbt2.sv
// Directed bench for hicore_icb_arbt2: bench plays both masters and the splitter.
// Expected commands/responses are queued at stimulus time and popped by monitors.
module tb_hicore_icb_arbt2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic            m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [AW-1:0]   m0_icb_cmd_addr;
  logic [DW-1:0]   m0_icb_cmd_wdata;
  logic [DW/8-1:0] m0_icb_cmd_wmask;
  logic            m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
  logic [DW-1:0]   m0_icb_rsp_rdata;
  logic            m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [AW-1:0]   m1_icb_cmd_addr;
  logic [DW-1:0]   m1_icb_cmd_wdata;
  logic [DW/8-1:0] m1_icb_cmd_wmask;
  logic            m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
  logic [DW-1:0]   m1_icb_rsp_rdata;
  logic            o_icb_cmd_valid, o_icb_cmd_ready, o_icb_cmd_read;
  logic [AW-1:0]   o_icb_cmd_addr;
  logic [DW-1:0]   o_icb_cmd_wdata;
  logic [DW/8-1:0] o_icb_cmd_wmask;
  logic            o_icb_rsp_valid, o_icb_rsp_ready, o_icb_rsp_err;
  logic [DW-1:0]   o_icb_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  // {read, addr} of each command expected at the splitter, in grant order
  logic [AW:0]   exp_cmd_q[$];
  // {master, err, rdata} of each response expected at a master
  logic [DW+1:0] exp_rsp_q[$];

  hicore_icb_arbt2 #(.AW(AW), .DW(DW), .OUTS_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
    .o_icb_cmd_read(o_icb_cmd_read), .o_icb_cmd_addr(o_icb_cmd_addr),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
    .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_rdata(o_icb_rsp_rdata)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: compare every handshake against the expected queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_icb_cmd_valid && o_icb_cmd_ready) begin
        if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
        else chk("cmd_mon", {31'd0, o_icb_cmd_read, o_icb_cmd_addr}, {31'd0, exp_cmd_q.pop_front()});
      end
      if (m0_icb_rsp_valid && m0_icb_rsp_ready) begin
        if (exp_rsp_q.size() == 0) chk("rsp_m0_unexpected", 64'd1, 64'd0);
        else chk("rsp_mon_m0", {30'd0, 1'b0, m0_icb_rsp_err, m0_icb_rsp_rdata}, {30'd0, exp_rsp_q.pop_front()});
      end
      if (m1_icb_rsp_valid && m1_icb_rsp_ready) begin
        if (exp_rsp_q.size() == 0) chk("rsp_m1_unexpected", 64'd1, 64'd0);
        else chk("rsp_mon_m1", {30'd0, 1'b1, m1_icb_rsp_err, m1_icb_rsp_rdata}, {30'd0, exp_rsp_q.pop_front()});
      end
    end
  end

  logic          mst [4];
  logic [AW-1:0] exp_addr;

  initial begin
    rst_n = 1'b0;
    m0_icb_cmd_valid = 0; m0_icb_cmd_read = 1; m0_icb_cmd_addr = '0;
    m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0; m0_icb_rsp_ready = 1;
    m1_icb_cmd_valid = 0; m1_icb_cmd_read = 1; m1_icb_cmd_addr = '0;
    m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0; m1_icb_rsp_ready = 1;
    o_icb_cmd_ready = 0; o_icb_rsp_valid = 0; o_icb_rsp_err = 0; o_icb_rsp_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", o_icb_cmd_valid, 0);
    chk("rst_rsp_ready", o_icb_rsp_ready, 0);
    step();
    rst_n = 1'b1;
    o_icb_cmd_ready = 1;
    @(negedge clk);
    chk("idle_m0_cmd_ready", m0_icb_cmd_ready, 0);
    chk("idle_m1_cmd_ready", m1_icb_cmd_ready, 0);

    // Single read from m1
    step();
    m1_icb_cmd_valid = 1; m1_icb_cmd_read = 1; m1_icb_cmd_addr = 32'h8000_0000;
    exp_cmd_q.push_back({1'b1, 32'h8000_0000});
    @(negedge clk);
    chk("s1_cmd_valid", o_icb_cmd_valid, 1);
    chk("s1_cmd_addr", o_icb_cmd_addr, 32'h8000_0000);
    chk("s1_m0_cmd_ready", m0_icb_cmd_ready, 0);
    step();
    m1_icb_cmd_valid = 0; o_icb_cmd_ready = 0;
    o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'h1234_5678; o_icb_rsp_err = 0;
    exp_rsp_q.push_back({1'b1, 1'b0, 32'h1234_5678});
    @(negedge clk);
    chk("s1_m0_rsp_valid", m0_icb_rsp_valid, 0);
    chk("s1_m1_rsp_valid", m1_icb_rsp_valid, 1);
    step();
    o_icb_rsp_valid = 0;

    // Contention for 4 cycles; a response each cycle keeps the FIFO from filling
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h100;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h200;
    o_icb_cmd_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
`ifdef HICORE_ICB_ARBT_RR_EN
      mst[i] = (i % 2 == 1);
`else
      mst[i] = 1'b0;
`endif
      exp_addr = mst[i] ? 32'h200 : 32'h100;
      exp_cmd_q.push_back({1'b1, exp_addr});
      if (i > 0) begin
        o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'hA0 + 32'(i - 1);
        exp_rsp_q.push_back({mst[i-1], 1'b0, 32'hA0 + 32'(i - 1)});
      end
      @(negedge clk);
      chk("s2_grant_addr", o_icb_cmd_addr, exp_addr);
    end
    step();
    m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0; o_icb_cmd_ready = 0;
    o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'hA3;
    exp_rsp_q.push_back({mst[3], 1'b0, 32'hA3});
    step();
    o_icb_rsp_valid = 0;

    // Grant lock: m1 stalls, m0 arrives in cycle 2 but must wait
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h300;
    @(negedge clk);
    chk("s3_c1_addr", o_icb_cmd_addr, 32'h300);
    step();
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h400;
    @(negedge clk);
    chk("s3_c2_addr", o_icb_cmd_addr, 32'h300);
    chk("s3_c2_m0_cmd_ready", m0_icb_cmd_ready, 0);
    step();
    @(negedge clk);
    chk("s3_c3_addr", o_icb_cmd_addr, 32'h300);
    step();
    o_icb_cmd_ready = 1;
    exp_cmd_q.push_back({1'b1, 32'h300});
    @(negedge clk);
    chk("s3_hsk_m1_cmd_ready", m1_icb_cmd_ready, 1);
    step();
    m1_icb_cmd_valid = 0;
    exp_cmd_q.push_back({1'b1, 32'h400});
    @(negedge clk);
    chk("s3_next_m0_cmd_ready", m0_icb_cmd_ready, 1);

    // Full stall: two outstanding, third waits; no same-cycle bypass on pop
    step();
    m0_icb_cmd_valid = 0;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h500;
    @(negedge clk);
    chk("s4_full_cmd_valid", o_icb_cmd_valid, 0);
    chk("s4_full_m1_cmd_ready", m1_icb_cmd_ready, 0);
    step();
    o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'h33;
    exp_rsp_q.push_back({1'b1, 1'b0, 32'h33});
    @(negedge clk);
    chk("s4_pop_no_bypass", m1_icb_cmd_ready, 0);
    step();
    o_icb_rsp_rdata = 32'h44;
    exp_rsp_q.push_back({1'b0, 1'b0, 32'h44});
    exp_cmd_q.push_back({1'b1, 32'h500});
    @(negedge clk);
    chk("s4_after_pop_m1_cmd_ready", m1_icb_cmd_ready, 1);
    step();
    m1_icb_cmd_valid = 0; o_icb_cmd_ready = 0;
    o_icb_rsp_rdata = 32'h55;
    exp_rsp_q.push_back({1'b1, 1'b0, 32'h55});
    @(negedge clk);
    chk("s4_last_rsp_m1_valid", m1_icb_rsp_valid, 1);
    step();
    o_icb_rsp_valid = 0;
    @(negedge clk);
    chk("s4_empty_rsp_ready", o_icb_rsp_ready, 0);

    // Interleave: m0 write then m1 read, error passed back to m0
    step();
    m0_icb_cmd_valid = 1; m0_icb_cmd_read = 0; m0_icb_cmd_addr = 32'h600;
    m0_icb_cmd_wdata = 32'hDEAD_BEEF; m0_icb_cmd_wmask = 4'hF;
    o_icb_cmd_ready = 1;
    exp_cmd_q.push_back({1'b0, 32'h600});
    @(negedge clk);
    chk("s5_wmask", o_icb_cmd_wmask, 4'hF);
    chk("s5_wdata", o_icb_cmd_wdata, 32'hDEAD_BEEF);
    step();
    m0_icb_cmd_valid = 0; m0_icb_cmd_read = 1;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h700;
    exp_cmd_q.push_back({1'b1, 32'h700});
    @(negedge clk);
    chk("s5_m1_addr", o_icb_cmd_addr, 32'h700);
    step();
    m1_icb_cmd_valid = 0; o_icb_cmd_ready = 0;
    o_icb_rsp_valid = 1; o_icb_rsp_err = 1; o_icb_rsp_rdata = 32'h0;
    exp_rsp_q.push_back({1'b0, 1'b1, 32'h0});
    @(negedge clk);
    chk("s5_m0_rsp_err", m0_icb_rsp_err & m0_icb_rsp_valid, 1);
    chk("s5_m1_rsp_valid_first", m1_icb_rsp_valid, 0);
    step();
    o_icb_rsp_err = 0; o_icb_rsp_rdata = 32'h77;
    exp_rsp_q.push_back({1'b1, 1'b0, 32'h77});
    @(negedge clk);
    chk("s5_m1_rsp_valid", m1_icb_rsp_valid, 1);
    step();
    o_icb_rsp_rdata = 32'hEE;
    @(negedge clk);
    chk("s5_stray_m0_rsp_valid", m0_icb_rsp_valid, 0);
    chk("s5_stray_m1_rsp_valid", m1_icb_rsp_valid, 0);
    step();
    o_icb_rsp_valid = 0;

    // Async reset with two commands outstanding
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'h800; o_icb_cmd_ready = 1;
    exp_cmd_q.push_back({1'b1, 32'h800});
    step();
    m0_icb_cmd_valid = 0;
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'h900;
    exp_cmd_q.push_back({1'b1, 32'h900});
    step();
    m1_icb_cmd_valid = 0; o_icb_cmd_ready = 0;
    o_icb_rsp_valid = 1; o_icb_rsp_rdata = 32'h99;
    #1;
    chk("s6_pre_rst_m0_rsp_valid", m0_icb_rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_m0_rsp_valid", m0_icb_rsp_valid, 0);
    chk("s6_rst_m1_rsp_valid", m1_icb_rsp_valid, 0);
    chk("s6_rst_rsp_ready", o_icb_rsp_ready, 0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_post_m0_rsp_valid", m0_icb_rsp_valid, 0);
    chk("s6_post_m1_rsp_valid", m1_icb_rsp_valid, 0);
    step();
    o_icb_rsp_valid = 0;

    // Reset clears a held lock: m0 wins once both request
    m1_icb_cmd_valid = 1; m1_icb_cmd_addr = 32'hA00;
    @(negedge clk);
    chk("s6_lock_addr", o_icb_cmd_addr, 32'hA00);
    step();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m0_icb_cmd_valid = 1; m0_icb_cmd_addr = 32'hB00;
    @(negedge clk);
    chk("s6_unlock_addr", o_icb_cmd_addr, 32'hB00);
    step();
    m0_icb_cmd_valid = 0; m1_icb_cmd_valid = 0;

    step();
    chk("end_cmd_q_empty", exp_cmd_q.size(), 0);
    chk("end_rsp_q_empty", exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hicore_icb_arbt2.md
Name: hicore_icb_arbt2

Overview:
- Two-master ICB arbiter placed directly upstream of the bus-interface splitter. It merges the LSU data port (master 0) and the IFU fetch port (master 1) onto the single ICB that feeds the splitter's i_icb_* inputs.
- A small outstanding-transaction FIFO records which master issued each accepted command, so every response is returned to the correct master.
- The command path is combinational (zero added latency). The response path is also combinational, steered by the FIFO head.

Parameters:
- AW, 32, address width (matches HiCore_ADDR_SIZE).
- DW, 32, data width (matches HiCore_REG_SIZE); wmask width is DW/8.
- OUTS_DEPTH, 2, maximum outstanding commands tracked (allowed range 1..8). The pointer width is derived internally.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- m0_icb_cmd_valid/ready/read  in/out/in  1 each  master 0 (LSU) command handshake and read flag
- m0_icb_cmd_addr  in  AW  master 0 address
- m0_icb_cmd_wdata  in  DW  master 0 write data
- m0_icb_cmd_wmask  in  DW/8  master 0 byte mask
- m0_icb_rsp_valid/ready/err  out/in/out  1 each  master 0 response handshake and error
- m0_icb_rsp_rdata  out  DW  master 0 read data
- m1_icb_* (same set as m0)  master 1 (IFU)
- o_icb_cmd_valid/ready/read  out/in/out  1 each  to splitter
- o_icb_cmd_addr  out  AW; o_icb_cmd_wdata  out  DW; o_icb_cmd_wmask  out  DW/8
- o_icb_rsp_valid/ready/err  in/out/in  1 each  from splitter
- o_icb_rsp_rdata  in  DW

Behaviour:
- Clocking and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset state:
  - FIFO empty, write/read pointers 0, count 0.
  - lock register 0, lock_sel 0, rr_last 1.
  - All *_ready and *_valid outputs evaluate to 0 while the FIFO is empty and no master requests.
- Full flag: full = (count == OUTS_DEPTH).
  - While full, o_icb_cmd_valid = 0 and m0/m1 cmd_ready = 0.
  - No same-cycle bypass: a response pop in the same cycle does not free space for a command in that cycle.
- Grant selection:
  - If lock = 1, sel = lock_sel.
  - Else if both masters are valid, the priority policy decides (see Optional Feature).
  - Else sel = whichever master is valid.
- Command output:
  - o_icb_cmd_* = muxed fields of master sel.
  - o_icb_cmd_valid = selected master valid & ~full.
  - Selected master cmd_ready = o_icb_cmd_ready & ~full. The non-selected master's cmd_ready = 0.
- Grant lock (keeps ICB valid stable):
  - If o_icb_cmd_valid & ~o_icb_cmd_ready: lock <= 1, lock_sel <= sel.
  - On cmd handshake: lock <= 0.
  - A locked master is never pre-empted, even by master 0.
- Push: on each cmd handshake, FIFO[wptr] <= sel, wptr increments modulo OUTS_DEPTH, count +1.
- Response routing:
  - When the FIFO is non-empty, head = FIFO[rptr].
  - Master head gets rsp_valid = o_icb_rsp_valid, with err/rdata passed through.
  - o_icb_rsp_ready = ready of master head.
  - The other master's rsp_valid = 0.
- Pop: on response handshake, rptr increments modulo OUTS_DEPTH, count -1.
  - A push and a pop in the same cycle leave count unchanged; both pointers advance.
- Empty FIFO: o_icb_rsp_ready = 0 and both m*_rsp_valid = 0. An unexpected o_icb_rsp_valid is ignored.
- Response ordering is strictly in issue order. The splitter below guarantees in-order responses.
- Reset mid-operation: all state clears immediately. In-flight responses are dropped.

Optional Feature:
- Macro: HICORE_ICB_ARBT_RR_EN.
- Defined: round-robin arbitration. On a contended, unlocked cycle, grant the master that is not rr_last. rr_last <= sel on every cmd handshake.
- Undefined: fixed priority, master 0 wins every contended unlocked cycle. rr_last is not implemented.

Test Plan:
- Single read, m1 only: m1 cmd addr 0x8000_0000 with o_icb_cmd_ready=1 -> same-cycle o_icb_cmd_valid=1 with addr 0x8000_0000. The response 1 cycle later with rdata 0x1234_5678 appears only on m1_icb_rsp, and m0_rsp_valid stays 0.
- Contention, fixed priority: m0 and m1 both valid for 4 cycles with ready=1 -> m0 is granted all 4 cycles. With HICORE_ICB_ARBT_RR_EN the grant order is m0, m1, m0, m1.
- Grant lock: m1 valid, o_icb_cmd_ready=0 for 3 cycles, then m0 asserts in cycle 2 -> o_icb_cmd addr and sel stay on m1 until the handshake; m0 is granted on the next cycle.
- Full stall (OUTS_DEPTH=2): issue 2 commands with no response -> the third has cmd_ready=0. After one response is popped, the third is accepted the next cycle, not the same cycle.
- Out-of-master interleave: m0 write (wmask 0xF), then m1 read, responses in order -> the first response goes to m0 with err passed through, the second to m1; count returns to 0.
- Async reset: assert rst_n=0 with 2 outstanding -> count=0 and lock=0 immediately. After release, m0_rsp_valid/m1_rsp_valid stay 0 even if o_icb_rsp_valid=1.
